// File: rtl/tt_sweep_checker_if.sv
// Purpose: bundles the sweep checker's control, result and DUT-facing signals.
// Latency: none; this is wiring only.
// Backpressure: none; start is a one-cycle request and results are level or pulse outputs.
interface tt_sweep_checker_if #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 2
);
    logic              start;
    logic [N_OUT-1:0]  dut_out;
    logic [N_IN-1:0]   stim;
    logic              busy;
    logic              done;
    logic              pass;
    logic [N_IN:0]     fail_count;
    logic              first_fail_valid;
    logic [N_IN-1:0]   first_fail_idx;

    // Checker side: takes the request and DUT response, drives stim and results.
    modport master (
        input  start, dut_out,
        output stim, busy, done, pass, fail_count, first_fail_valid, first_fail_idx
    );

    // Host/DUT side: issues the request and response, observes stim and results.
    modport slave (
        output start, dut_out,
        input  stim, busy, done, pass, fail_count, first_fail_valid, first_fail_idx
    );
endinterface

// File: rtl/tt_sweep_checker.sv
// Purpose: sweeps all 2^N_IN stim vectors into a combinational DUT and checks each response against EXP_TABLE.
// Latency: done pulses after edge 2^N_IN*(SETTLE_CYC+1), counting the start-sampling edge as edge 0.
// Backpressure: none; start is ignored while busy or in DONE. Optional TT_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module tt_sweep_checker #(
    parameter int N_IN       = 3,
    parameter int N_OUT      = 2,
    parameter int SETTLE_CYC = 1,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXP_TABLE = 16'h0A1D
) (
    input  logic               clk,
    input  logic               n_reset,
    tt_sweep_checker_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_DONE} state_t;

    localparam logic [7:0]      RELOAD   = 8'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0] LAST_IDX = '1;

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [N_IN-1:0]    stim_q, stim_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [N_IN:0]      fail_q, fail_d;
    logic               ffv_q, ffv_d;
    logic [N_IN-1:0]    ffi_q, ffi_d;

    // Expected table unpacked per index so the lookup is a plain array select on stim.
    logic [N_OUT-1:0]   exp_arr [2**N_IN];
    logic [N_OUT-1:0]   exp_val;
    logic               mismatch;
    logic               last;

    for (genvar g = 0; g < 2**N_IN; g++) begin : g_exp
        assign exp_arr[g] = EXP_TABLE[g*N_OUT +: N_OUT];
    end

    assign exp_val  = exp_arr[stim_q];
    assign mismatch = (bus.dut_out != exp_val);
    assign last     = (stim_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state: settle countdown, one-cycle check, end after the last index (or first mismatch when stopping on fail).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start) state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == 8'd0) state_d = S_CHECK;
            S_CHECK: begin
`ifdef TT_STOP_ON_FAIL_EN
                if (mismatch || last) state_d = S_DONE;
                else                  state_d = S_SETTLE;
`else
                if (last) state_d = S_DONE;
                else      state_d = S_SETTLE;
`endif
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; everything lands in registers so dut_out never reaches an output combinationally.
    always_comb begin
        cnt_d  = cnt_q;
        stim_d = stim_q;
        busy_d = busy_q;
        done_d = 1'b0;
        pass_d = pass_q;
        fail_d = fail_q;
        ffv_d  = ffv_q;
        ffi_d  = ffi_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    fail_d = '0;
                    pass_d = 1'b0;
                    ffv_d  = 1'b0;
                    ffi_d  = '0;
                    stim_d = '0;
                    cnt_d  = RELOAD;
                    busy_d = 1'b1;
                end
            end
            S_SETTLE: begin
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            end
            S_CHECK: begin
                if (mismatch) begin
                    fail_d = fail_q + (N_IN+1)'(1);
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = stim_q;
                    end
                end
                if (state_d == S_SETTLE) begin
                    stim_d = stim_q + N_IN'(1);
                    cnt_d  = RELOAD;
                end else begin
                    // Leaving for DONE: the pulse and verdict appear together in the DONE cycle.
                    done_d = 1'b1;
                    pass_d = (fail_d == '0);
                end
            end
            S_DONE: busy_d = 1'b0;
            default: ;
        endcase
    end

    // Datapath and result registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q  <= '0;
            stim_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= '0;
            ffv_q  <= 1'b0;
            ffi_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            stim_q <= stim_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            ffv_q  <= ffv_d;
            ffi_q  <= ffi_d;
        end
    end

    assign bus.stim             = stim_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.fail_count       = fail_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Purpose: directed scoreboard bench for tt_sweep_checker with a table-driven DUT model.
// Latency: expected done edge is recorded per sweep and checked when done is seen.
// Backpressure: n/a; expectations are honoured for both plain and TT_STOP_ON_FAIL_EN builds.
module tb_tt_sweep_checker;

    typedef struct {
        int edge_n;
        int pass;
        int fc;
        int ffv;
        int ffi;
        int stim;
    } exp_t;

`ifdef TT_STOP_ON_FAIL_EN
    localparam bit SOF = 1'b1;
`else
    localparam bit SOF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic [15:0] model_tbl = 16'h0A1D;
    int          ecnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    tt_sweep_checker_if #(.N_IN(3), .N_OUT(2)) bus ();

    tt_sweep_checker #(
        .N_IN(3), .N_OUT(2), .SETTLE_CYC(1), .EXP_TABLE(16'h0A1D)
    ) u_dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    // Combinational DUT model: 2 output bits per stim index.
    always_comb bus.dut_out = model_tbl[{bus.stim, 1'b0} +: 2];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic push_exp(input int e_edge, input int p, input int fc, input int ffv, input int ffi, input int st);
        exp_t e;
        e.edge_n = e_edge; e.pass = p; e.fc = fc; e.ffv = ffv; e.ffi = ffi; e.stim = st;
        sb.push_back(e);
    endtask

    // Monitor: each done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: done=1 at edge %0d, expected no pending sweep", ecnt);
            end else begin
                mon_e = sb.pop_front();
                chk("done_edge",  ecnt, mon_e.edge_n);
                chk("pass",       int'(bus.pass), mon_e.pass);
                chk("fail_count", int'(bus.fail_count), mon_e.fc);
                chk("ff_valid",   int'(bus.first_fail_valid), mon_e.ffv);
                if (mon_e.ffv != 0) chk("ff_idx", int'(bus.first_fail_idx), mon_e.ffi);
                chk("final_stim", int'(bus.stim), mon_e.stim);
            end
        end
    end

    task automatic start_sweep(output int s);
        @(negedge clk);
        bus.start = 1'b1;
        s = ecnt + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int i = 0;
        while (bus.done !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: done=%b, expected 1 within 200 cycles", name, bus.done);
        end
        @(negedge clk);
        chk({name, "_done_low"}, int'(bus.done), 0);
        chk({name, "_busy_low"}, int'(bus.busy), 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_stim"}, int'(bus.stim), 0);
        chk({name, "_busy"}, int'(bus.busy), 0);
        chk({name, "_done"}, int'(bus.done), 0);
        chk({name, "_pass"}, int'(bus.pass), 0);
        chk({name, "_fc"},   int'(bus.fail_count), 0);
        chk({name, "_ffv"},  int'(bus.first_fail_valid), 0);
        chk({name, "_ffi"},  int'(bus.first_fail_idx), 0);
    endtask

    initial begin
        int s;
        int L;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        n_reset = 1'b1;
        @(negedge clk);

        // T1: matching DUT, with start re-pulsed at edges 5 and 9 (ignored).
        model_tbl = 16'h0A1D;
        start_sweep(s);
        push_exp(s + 16, 1, 0, 0, 0, 7);
        for (int k = 0; k < 16; k++) begin
            chk("t1_stim", int'(bus.stim), k / 2);
            chk("t1_busy", int'(bus.busy), 1);
            bus.start = (k == 4 || k == 8);
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_done("t1");
        chk("t1_pass_held", int'(bus.pass), 1);

        // T2: index 3 -> 11 and index 6 -> 01.
        model_tbl = 16'h1ADD;
        start_sweep(s);
        if (SOF) push_exp(s + 8, 0, 1, 1, 3, 3);
        else     push_exp(s + 16, 0, 2, 1, 3, 7);
        wait_done("t2");

        // T3: outputs stuck at 11; only index 1 matches.
        model_tbl = 16'hFFFF;
        start_sweep(s);
        if (SOF) push_exp(s + 2, 0, 1, 1, 0, 0);
        else     push_exp(s + 16, 0, 7, 1, 0, 7);
        wait_done("t3");

        // T6: single mismatch at index 2.
        model_tbl = 16'h0A2D;
        start_sweep(s);
        if (SOF) push_exp(s + 6, 0, 1, 1, 2, 2);
        else     push_exp(s + 16, 0, 1, 1, 2, 7);
        wait_done("t6");
        if (SOF) chk("t6_stim_held", int'(bus.stim), 2);

        // T5: reset dropped after edge 7 aborts the sweep silently.
        model_tbl = 16'h1ADD;
        start_sweep(s);
        repeat (7) @(negedge clk);
        chk("t5_stim_pre", int'(bus.stim), 3);
        chk("t5_busy_pre", int'(bus.busy), 1);
        n_reset = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        repeat (2) @(negedge clk);
        chk("t5_done_in_rst", int'(bus.done), 0);
        n_reset = 1'b1;
        model_tbl = 16'h0A1D;
        start_sweep(s);
        push_exp(s + 16, 1, 0, 0, 0, 7);
        wait_done("t5_clean");

        // T7: start held high: back-to-back sweeps, results cleared on re-acceptance.
        model_tbl = 16'hFFFF;
        L = SOF ? 2 : 16;
        @(negedge clk);
        bus.start = 1'b1;
        s = ecnt + 1;
        if (SOF) begin
            push_exp(s + L, 0, 1, 1, 0, 0);
            push_exp(s + 2*L + 2, 0, 1, 1, 0, 0);
        end else begin
            push_exp(s + L, 0, 7, 1, 0, 7);
            push_exp(s + 2*L + 2, 0, 7, 1, 0, 7);
        end
        repeat (L + 3) @(negedge clk);
        chk("t7_busy", int'(bus.busy), 1);
        chk("t7_fc_clr", int'(bus.fail_count), 0);
        chk("t7_ffv_clr", int'(bus.first_fail_valid), 0);
        chk("t7_pass_clr", int'(bus.pass), 0);
        chk("t7_stim", int'(bus.stim), 0);
        bus.start = 1'b0;
        wait_done("t7");

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Sequential, parametrised successor to the 3-input/2-output truth-table check flow. Replaces a hand-written per-vector bench with synthesisable hardware.
- On request, sweeps all 2^N_IN input combinations into a combinational DUT and waits a programmable settle time after each one.
- Compares each DUT response against a packed expected-value table and counts mismatches.
- Sits beside the DUT in on-board self-test and in simulation benches; its result flags can drive LEDs or a status register.

Parameters:
- N_IN, 3, number of DUT inputs (1..8); the sweep covers indices 0 .. 2^N_IN-1.
- N_OUT, 2, number of DUT outputs (1..8).
- SETTLE_CYC, 1, clock cycles stim is held before sampling (1..255).
- EXP_TABLE, 16'h0A1D, packed expected outputs of width (2^N_IN)*N_OUT. The expected value for index i is EXP_TABLE[i*N_OUT +: N_OUT].
  - Default encodes 000->01, 001->11, 010->01, 011->00, 100->10, 101->10, 110->00, 111->00.
  - Stim MSB is the first-named DUT input (A).

Ports:
- clk  in  1  system clock, rising edge.
- n_reset  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep; sampled only in IDLE.
- dut_out  in  N_OUT  DUT response to stim.
- stim  out  N_IN  registered vector driven to the DUT.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  high when the last completed sweep had fail_count==0; held until the next start is accepted.
- fail_count  out  N_IN+1  number of mismatching vectors in the current or last sweep.
- first_fail_valid  out  1  at least one mismatch has been recorded.
- first_fail_idx  out  N_IN  lowest index that mismatched; valid only when first_fail_valid is high.

Behaviour:
- Reset (n_reset low, asynchronous): FSM goes to IDLE. stim, busy, done, pass, fail_count, first_fail_valid, first_fail_idx and the internal counters all go to 0. Reset asserted mid-sweep aborts the sweep with no done pulse.
- All outputs are registered. There is no combinational path from dut_out to any output.
- FSM states are IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 at an edge: clear fail_count, pass, first_fail_valid and first_fail_idx; set stim=0, set the settle counter to SETTLE_CYC-1, set busy=1; go to SETTLE.
  - start=0: hold all outputs.
- SETTLE: decrement the settle counter each edge; at 0, go to CHECK. stim is stable throughout.
- CHECK (one cycle):
  - Compare dut_out with the expected value for index stim.
  - On mismatch: fail_count increments. If first_fail_valid is 0, latch first_fail_idx=stim and set first_fail_valid=1.
  - If stim==2^N_IN-1: go to DONE.
  - Otherwise: stim increments by 1, the settle counter is reloaded, go to SETTLE.
  - stim never wraps within a sweep.
- DONE (one cycle): done=1, pass=(fail_count==0), busy=0 on exit; go to IDLE. The next cycle has done=0.
- Latency: edge 0 is the edge that samples start. done is high after edge 2^N_IN*(SETTLE_CYC+1). Default: done is high after edge 16.
- start while busy or in DONE is ignored; there is no queuing.
- start held high continuously: a new sweep begins in the IDLE cycle after each DONE, and results are cleared on each acceptance.
- fail_count width N_IN+1 holds the all-fail count 2^N_IN without overflow.

Optional Feature:
- Macro: TT_STOP_ON_FAIL_EN.
- When defined: a mismatch in CHECK goes directly to DONE instead of advancing.
  - fail_count ends at 1, pass=0, and first_fail_idx equals the stim value at the final CHECK.
  - stim holds the failing vector until the next start is accepted.
  - done latency is (first_fail_idx+1)*(SETTLE_CYC+1).
- When undefined: the full sweep always runs, as described in Behaviour.

Test Plan:
- Default parameters, DUT model matches the default table, pulse start -> done high after edge 16; pass=1, fail_count=0, first_fail_valid=0; stim stepped 0..7 with each value held 2 cycles.
- DUT model with index 3 forced to 11 (expected 00) and index 6 forced to 01 -> done after edge 16; pass=0, fail_count=2, first_fail_idx=3.
- DUT outputs stuck at 2'b11 -> fail_count=7 (only index 1 matches), first_fail_idx=0, pass=0.
- start re-pulsed at edges 5 and 9 of a running sweep -> ignored; exactly one done pulse, at edge 16; busy stays high throughout.
- n_reset dropped at edge 7 mid-sweep -> all outputs 0 immediately with no done pulse; after release, start -> a clean 16-cycle sweep.
- Build with TT_STOP_ON_FAIL_EN and a mismatch at index 2 -> done after edge 6; stim=2, fail_count=1, first_fail_idx=2, pass=0.
